// File: rtl/cdb_result_buffer_if.sv
// Handshake bundle between a functional unit, its CDB result buffer and the CDB arbiter.
// The slave modport is the buffer's view; master is the producer/arbiter side.
interface cdb_result_buffer_if #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_value;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 request;
    logic                 grant;
    logic [XLEN-1:0]      cdb_value;
    logic [TAG_WIDTH-1:0] cdb_tag;

    modport master (
        output in_valid, in_value, in_tag, grant,
        input  in_ready, request, cdb_value, cdb_tag
    );

    modport slave (
        input  in_valid, in_value, in_tag, grant,
        output in_ready, request, cdb_value, cdb_tag
    );
endinterface

// File: rtl/cdb_result_buffer.sv
// Circular FIFO holding functional-unit results until the CDB arbiter grants a broadcast slot.
// Head entry is presented combinationally; entries only become visible the cycle after they are written.
module cdb_result_buffer #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    cdb_result_buffer_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]      value;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;

    // Both handshake outputs depend on occupancy only, so grant never reaches in_ready.
    assign bus.request  = (count_q != '0);
    assign bus.in_ready = (count_q < CNT_W'(DEPTH));
    assign count        = count_q;

    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.grant && bus.request && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; occupancy is tracked by count_q, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{value: bus.in_value, tag: bus.in_tag};
        end
    end

    // NOTE: outputs get a default before the conditional so no latch is inferred.
    always_comb begin
        bus.cdb_value = '0;
        bus.cdb_tag   = '0;
        if (bus.request) begin
            bus.cdb_value = mem[head].value;
            bus.cdb_tag   = mem[head].tag;
        end
    end
endmodule

// File: tb/tb_cdb_result_buffer.sv
// Self-checking bench: a queue scoreboard models the FIFO every cycle, plus a vector table
// and directed sequences for fill, wrap-around, flush, async reset and grant-while-empty.
module tb_cdb_result_buffer;
    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 5;
    localparam int DEPTH     = 4;

    typedef struct packed {
        logic [XLEN-1:0]      value;
        logic [TAG_WIDTH-1:0] tag;
    } sb_t;

    typedef struct {
        logic                 in_valid;
        logic [XLEN-1:0]      in_value;
        logic [TAG_WIDTH-1:0] in_tag;
        logic                 grant;
        logic                 flush;
        logic                 exp_request;
        logic [2:0]           exp_count;
        logic [TAG_WIDTH-1:0] exp_tag;
        logic [XLEN-1:0]      exp_value;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    sb_t sb_q[$];
    vec_t vecs[6];

    cdb_result_buffer_if #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH)) bus ();

    cdb_result_buffer #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the scoreboard's pre-edge state.
    task automatic check_model(input string tagname);
        sb_t head;
        head = (sb_q.size() != 0) ? sb_q[0] : '0;
        check({tagname, ".request"},  64'(bus.request),   64'(sb_q.size() != 0));
        check({tagname, ".in_ready"}, 64'(bus.in_ready),  64'(sb_q.size() < DEPTH));
        check({tagname, ".count"},    64'(count),         64'(sb_q.size()));
        check({tagname, ".cdb_tag"},  64'(bus.cdb_tag),   64'(head.tag));
        check({tagname, ".cdb_value"},64'(bus.cdb_value), 64'(head.value));
    endtask

    // Drive one cycle after the falling edge, check, then advance the model to the next edge.
    task automatic step(input logic iv, input logic [XLEN-1:0] val, input logic [TAG_WIDTH-1:0] tg,
                        input logic gr, input logic fl);
        logic do_push;
        logic do_pop;
        @(negedge clk);
        bus.in_valid = iv;
        bus.in_value = val;
        bus.in_tag   = tg;
        bus.grant    = gr;
        flush        = fl;
        #1;
        check_model("sb");
        do_push = iv && (sb_q.size() < DEPTH);
        do_pop  = gr && (sb_q.size() != 0);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (do_pop) void'(sb_q.pop_front());
            if (do_push) sb_q.push_back('{value: val, tag: tg});
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_tag   = '0;
        bus.grant    = 1'b0;

        // Single push held without grant, then popped.
        vecs[0] = '{1'b1, 32'h11, 5'd3, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0};
        vecs[1] = '{1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 5'd3, 32'h11};
        vecs[2] = '{1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 5'd3, 32'h11};
        vecs[3] = '{1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 5'd3, 32'h11};
        vecs[4] = '{1'b0, 32'h00, 5'd0, 1'b1, 1'b0, 1'b1, 3'd1, 5'd3, 32'h11};
        vecs[5] = '{1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0};

        #2;
        check("reset.request",   64'(bus.request),   64'd0);
        check("reset.in_ready",  64'(bus.in_ready),  64'd1);
        check("reset.count",     64'(count),         64'd0);
        check("reset.cdb_tag",   64'(bus.cdb_tag),   64'd0);
        check("reset.cdb_value", 64'(bus.cdb_value), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            step(vecs[i].in_valid, vecs[i].in_value, vecs[i].in_tag, vecs[i].grant, vecs[i].flush);
            check($sformatf("vec%0d.request", i),   64'(bus.request),   64'(vecs[i].exp_request));
            check($sformatf("vec%0d.count", i),     64'(count),         64'(vecs[i].exp_count));
            check($sformatf("vec%0d.cdb_tag", i),   64'(bus.cdb_tag),   64'(vecs[i].exp_tag));
            check($sformatf("vec%0d.cdb_value", i), 64'(bus.cdb_value), 64'(vecs[i].exp_value));
        end

        // Fill to DEPTH; a fifth offer is refused, including while grant frees a slot.
        for (int t = 1; t <= DEPTH; t++) step(1'b1, $urandom, TAG_WIDTH'(t), 1'b0, 1'b0);
        step(1'b1, 32'hdead, 5'd5, 1'b0, 1'b0);
        check("full.count",    64'(count),        64'd4);
        check("full.in_ready", 64'(bus.in_ready), 64'd0);
        step(1'b1, 32'hbeef, 5'd6, 1'b1, 1'b0);
        check("full_grant.in_ready", 64'(bus.in_ready), 64'd0);
        check("drain.tag1", 64'(bus.cdb_tag), 64'd1);
        for (int t = 2; t <= DEPTH; t++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            check($sformatf("drain.tag%0d", t), 64'(bus.cdb_tag), 64'(t));
        end
        idle();
        check("drained.request", 64'(bus.request), 64'd0);

        // Wrap-around: steady push+pop at occupancy one.
        step(1'b1, $urandom, 5'd10, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, $urandom, TAG_WIDTH'(11 + k), 1'b1, 1'b0);
            check($sformatf("wrap%0d.count", k), 64'(count),       64'd1);
            check($sformatf("wrap%0d.tag", k),   64'(bus.cdb_tag), 64'(10 + k));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        idle();
        check("wrap_end.count", 64'(count), 64'd0);

        // Flush with three entries and a concurrent push and grant.
        for (int t = 0; t < 3; t++) step(1'b1, $urandom, TAG_WIDTH'(20 + t), 1'b0, 1'b0);
        step(1'b1, 32'h55, 5'd30, 1'b1, 1'b1);
        check("flush_cycle.request", 64'(bus.request), 64'd1);
        check("flush_cycle.count",   64'(count),       64'd3);
        idle();
        check("post_flush.count",    64'(count),        64'd0);
        check("post_flush.request",  64'(bus.request),  64'd0);
        check("post_flush.in_ready", 64'(bus.in_ready), 64'd1);

        // Asynchronous reset pulse between edges with two entries held.
        step(1'b1, $urandom, 5'd7, 1'b0, 1'b0);
        step(1'b1, $urandom, 5'd8, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.grant    = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst.request", 64'(bus.request), 64'd0);
        check("async_rst.count",   64'(count),       64'd0);
        #1 reset = 1'b0;
        sb_q.delete();
        idle();
        idle();
        check("post_rst.request", 64'(bus.request), 64'd0);

        // Grant while empty must not disturb later traffic.
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("empty_grant.count", 64'(count), 64'd0);
        step(1'b1, 32'hcafe, 5'd9, 1'b0, 1'b0);
        step(1'b1, 32'hf00d, 5'd12, 1'b0, 1'b0);
        check("after_empty.tag",   64'(bus.cdb_tag),   64'd9);
        check("after_empty.value", 64'(bus.cdb_value), 64'hcafe);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("after_empty.tag2", 64'(bus.cdb_tag), 64'd12);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_result_buffer.md
CDB_RESULT_BUFFER -- requirements
Module: cdb_result_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, the width of the result value.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, the width of the ROB destination tag.
REQ-003 SHALL have parameter DEPTH, default 4, the number of entries; it SHALL be a power of two and at least 2.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous pipeline flush (mispredict); discards all entries.
REQ-007 in_valid  input  1  the functional unit presents a result.
REQ-008 in_ready  output  1  the buffer can accept a result this cycle.
REQ-009 in_value  input  XLEN  result value from the functional unit.
REQ-010 in_tag  input  TAG_WIDTH  ROB tag of the result.
REQ-011 request  output  1  this unit's request bit to the CDB arbiter.
REQ-012 grant  input  1  this unit's one-hot grant bit from the CDB arbiter.
REQ-013 cdb_value  output  XLEN  head-entry value driven toward the CDB.
REQ-014 cdb_tag  output  TAG_WIDTH  head-entry tag driven toward the CDB.
REQ-015 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-016 SHALL be a circular FIFO with head and tail pointers of width $clog2(DEPTH), each wrapping from DEPTH-1 to 0.
REQ-017 SHALL drive request = (count != 0), combinationally from state only.
REQ-018 SHALL drive in_ready = (count < DEPTH), from state only, with no combinational path from grant.
REQ-019 SHALL push, meaning it writes {in_value, in_tag} at the tail and advances the tail, when in_valid && in_ready && !flush.
REQ-020 SHALL pop, meaning it advances the head, when grant && request && !flush.
REQ-021 SHALL ignore grant while request is 0; no state change occurs.
REQ-022 SHALL ignore in_valid while in_ready is 0; the producer holds its data.
REQ-023 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 Push-to-request latency SHALL be 1 cycle, with no same-cycle bypass: an entry written at edge N requests from cycle N+1.
REQ-025 cdb_value and cdb_tag SHALL combinationally show the head entry while request is 1, and SHALL be 0 while empty.
REQ-026 Entries SHALL leave in arrival order; the head entry SHALL NOT change while request is high and grant is low.
REQ-027 When flush is 1, the next edge SHALL clear count and both pointers, and any push or pop in that cycle SHALL be discarded.
REQ-028 request and outputs SHALL still reflect the pre-flush state during the flush cycle.
REQ-029 At count == DEPTH with grant high, in_ready SHALL remain 0 that cycle; there is no pass-through.
REQ-030 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-031 Asserting reset SHALL immediately clear count, head and tail regardless of clk.
REQ-032 During reset, request SHALL be 0, in_ready SHALL be 1, and cdb_value, cdb_tag and count SHALL be 0.
REQ-033 Reset SHALL take priority over flush, push and pop.
REQ-034 Reset asserted mid-operation SHALL discard all entries; there SHALL be no spurious request on release.
REQ-035 Entry storage contents need not be cleared by reset.

Verification
REQ-036 Single push, tag 3 / value 0x11 at cycle 0, grant held low: the bench SHALL check request=1 from cycle 1 with cdb_tag=3 and cdb_value=0x11 held stable; grant at cycle 4 pops it, and request=0 with outputs 0 at cycle 5.
REQ-037 Fill with DEPTH=4 pushes, tags 1..4, no grant: the bench SHALL check count=4 and in_ready=0; a 5th in_valid SHALL be ignored; four grant cycles SHALL yield tags 1,2,3,4 in order.
REQ-038 Wrap-around: the bench SHALL perform 10 push/pop pairs interleaved at count=1 and check the tag order is preserved across pointer wrap and count stays 1 at each simultaneous push+pop.
REQ-039 Flush with count=3, concurrent push and grant: the bench SHALL check request was 1 during the flush cycle and count=0, request=0, in_ready=1 after the edge.
REQ-040 Async reset pulse between edges with count=2: the bench SHALL check request=0 and count=0 immediately, and no request after release.
REQ-041 Grant while empty: the bench SHALL check count stays 0, pointers are unchanged, and a following push/pop sequence is unaffected.
